// File: rtl/gpredict_resolve_queue_pkg.sv
// Shared types for the global-predictor resolution queue.
// Entry record, FSM state encoding and default widths.
package gpredict_resolve_queue_pkg;

  localparam int RQ_PC_W  = 8;
  localparam int RQ_IDX_W = 4;

  typedef struct packed {
    logic [RQ_PC_W-1:0]  pc;
    logic [RQ_IDX_W-1:0] index;
    logic                taken;
  } rq_entry_t;

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } rq_state_e;

endpackage

// File: rtl/gpredict_resolve_queue_if.sv
// Predict/resolve/update bundle for the resolution queue.
// master = predictor+execute side, slave = queue.
interface gpredict_resolve_queue_if #(
  parameter int PC_W  = 8,
  parameter int IDX_W = 4,
  parameter int CNT_W = 3
);
  logic             pred_valid;
  logic [PC_W-1:0]  pred_pc;
  logic [IDX_W-1:0] pred_index;
  logic             pred_taken;
  logic             pred_ready;
  logic             res_valid;
  logic             res_taken;
  logic             res_ready;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_index;
  logic             upd_taken;
  logic             mispredict;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] count;

  modport master (
    output pred_valid, pred_pc, pred_index, pred_taken,
    output res_valid, res_taken,
    input  pred_ready, res_ready,
    input  upd_valid, upd_index, upd_taken,
    input  mispredict, redirect_pc, count
  );

  modport slave (
    input  pred_valid, pred_pc, pred_index, pred_taken,
    input  res_valid, res_taken,
    output pred_ready, res_ready,
    output upd_valid, upd_index, upd_taken,
    output mispredict, redirect_pc, count
  );
endinterface

// File: rtl/gpredict_rq_storage.sv
// Circular-buffer register array for the resolution queue.
// Write at tail address, asynchronous read at head address.
module gpredict_rq_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 13,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/gpredict_resolve_queue.sv
// In-order branch resolution queue: BHT update, mispredict
// redirect, younger-entry squash and push blocking window.
module gpredict_resolve_queue
  import gpredict_resolve_queue_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int PC_W           = RQ_PC_W,
  parameter int IDX_W          = RQ_IDX_W,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic clk,
  input  logic reset_n,
  gpredict_resolve_queue_if.slave bus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int EW  = PC_W + IDX_W + 1;
  localparam int RCW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [IDX_W-1:0] index;
    logic             taken;
  } entry_t;

  logic [PW-1:0]  r_head, r_tail;
  rq_state_e      r_state, w_state_nx;
  logic [RCW-1:0] r_rcnt, w_rcnt_nx;

  logic           w_full, w_empty;
  logic           w_push, w_pop, w_mis;
  entry_t         w_wr, w_rd;
  logic [EW-1:0]  w_rd_raw;

  assign w_full  = (r_head[AW-1:0] == r_tail[AW-1:0]) &&
                   (r_head[AW] != r_tail[AW]);
  assign w_empty = (r_head == r_tail);

  assign bus.pred_ready = !w_full && (r_state == NORMAL);
  assign bus.res_ready  = !w_empty;
  assign bus.count      = r_tail - r_head;

  assign w_push = bus.pred_valid && bus.pred_ready;
  assign w_pop  = bus.res_valid && bus.res_ready;
  assign w_rd   = entry_t'(w_rd_raw);
  assign w_mis  = w_pop && (w_rd.taken != bus.res_taken);
  assign w_wr   = '{pc: bus.pred_pc, index: bus.pred_index,
                    taken: bus.pred_taken};

  gpredict_rq_storage #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_storage (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_we    (w_push && !w_mis),
    .i_waddr (r_tail[AW-1:0]),
    .i_wdata (w_wr),
    .i_raddr (r_head[AW-1:0]),
    .o_rdata (w_rd_raw)
  );

  // A mispredict squashes everything younger, incl. a same-cycle push
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_pop) r_head <= r_head + PW'(1);
      if (w_mis)       r_tail <= r_head + PW'(1);
      else if (w_push) r_tail <= r_tail + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.upd_valid   <= 1'b0;
      bus.upd_index   <= '0;
      bus.upd_taken   <= 1'b0;
      bus.mispredict  <= 1'b0;
      bus.redirect_pc <= '0;
    end else begin
      bus.upd_valid  <= w_pop;
      bus.mispredict <= w_mis;
      if (w_pop) begin
        bus.upd_index <= w_rd.index;
        bus.upd_taken <= bus.res_taken;
      end
      if (w_mis) bus.redirect_pc <= w_rd.pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= NORMAL;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_rcnt  <= w_rcnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_rcnt_nx  = r_rcnt;
    unique case (r_state)
      NORMAL: begin
        if (w_mis) begin
          w_state_nx = RECOVER;
          w_rcnt_nx  = RCW'(RECOVER_CYCLES - 1);
        end
      end
      RECOVER: begin
        if (r_rcnt == '0) w_state_nx = NORMAL;
        else              w_rcnt_nx  = r_rcnt - RCW'(1);
      end
      default: w_state_nx = NORMAL;
    endcase
  end

endmodule

// File: tb/tb_gpredict_resolve_queue.sv
// Bench for gpredict_resolve_queue: vector table, queue
// reference model with update scoreboard, reset corner cases.
module tb_gpredict_resolve_queue;
  import gpredict_resolve_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int RECOVER_CYCLES = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gpredict_resolve_queue_if #(
    .PC_W(8), .IDX_W(4), .CNT_W(CNT_W)
  ) bus ();

  gpredict_resolve_queue #(
    .DEPTH(DEPTH), .PC_W(8), .IDX_W(4),
    .RECOVER_CYCLES(RECOVER_CYCLES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  typedef struct {
    logic [3:0] idx;
    logic       taken;
    logic       mis;
    logic [7:0] pc;
  } upd_t;

  typedef struct {
    logic       pv;
    logic [7:0] pc;
    logic [3:0] ix;
    logic       tk;
    logic       rv;
    logic       rt;
    int         cnt;
  } vec_t;

  rq_entry_t mq[$];
  upd_t      sbq[$];
  int        mrec = 0;
  int        total = 0;
  int        bad = 0;
  vec_t      vt[22];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pv, input logic [7:0] pc,
                       input logic [3:0] ix, input logic tk,
                       input logic rv, input logic rt);
    bus.pred_valid = pv;
    bus.pred_pc    = pc;
    bus.pred_index = ix;
    bus.pred_taken = tk;
    bus.res_valid  = rv;
    bus.res_taken  = rt;
  endtask

  task automatic step(input logic pv, input logic [7:0] pc,
                      input logic [3:0] ix, input logic tk,
                      input logic rv, input logic rt);
    logic mp, mr, pu, po, mis;
    rq_entry_t e;
    upd_t u;
    mp = (mq.size() < DEPTH) && (mrec == 0);
    mr = (mq.size() != 0);
    chk("pred_ready", 32'(bus.pred_ready), 32'(mp));
    chk("res_ready", 32'(bus.res_ready), 32'(mr));
    chk("count", 32'(bus.count), 32'(mq.size()));
    drive(pv, pc, ix, tk, rv, rt);
    pu = pv && mp;
    po = rv && mr;
    mis = 1'b0;
    if (po) begin
      e = mq.pop_front();
      mis = (e.taken != rt);
      u = '{idx: e.index, taken: rt, mis: mis, pc: e.pc};
      sbq.push_back(u);
    end
    if (mis) begin
      mq.delete();
      mrec = RECOVER_CYCLES;
    end else begin
      if (pu) mq.push_back('{pc: pc, index: ix, taken: tk});
      if (mrec > 0) mrec--;
    end
    @(posedge clk);
    #1;
    chk("upd_valid", 32'(bus.upd_valid), 32'(po));
    chk("mispredict", 32'(bus.mispredict), 32'(mis));
    if (po) begin
      u = sbq.pop_front();
      if (bus.upd_valid) begin
        chk("upd_index", 32'(bus.upd_index), 32'(u.idx));
        chk("upd_taken", 32'(bus.upd_taken), 32'(u.taken));
        if (u.mis)
          chk("redirect_pc", 32'(bus.redirect_pc), 32'(u.pc));
      end
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_upd_valid", 32'(bus.upd_valid), 0);
    chk("rst_upd_index", 32'(bus.upd_index), 0);
    chk("rst_upd_taken", 32'(bus.upd_taken), 0);
    chk("rst_mispredict", 32'(bus.mispredict), 0);
    chk("rst_redirect_pc", 32'(bus.redirect_pc), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_pred_ready", 32'(bus.pred_ready), 1);
    chk("rst_res_ready", 32'(bus.res_ready), 0);
  endtask

  initial begin
    vt[0]  = '{1, 8'h10, 4'h1, 1, 0, 0, 1};
    vt[1]  = '{1, 8'h11, 4'h2, 1, 0, 0, 2};
    vt[2]  = '{1, 8'h12, 4'h3, 1, 0, 0, 3};
    vt[3]  = '{1, 8'h13, 4'h4, 1, 0, 0, 4};
    vt[4]  = '{1, 8'h14, 4'h9, 1, 0, 0, 4};
    vt[5]  = '{1, 8'h15, 4'h9, 1, 1, 1, 3};
    vt[6]  = '{0, 8'h00, 4'h0, 0, 1, 1, 2};
    vt[7]  = '{0, 8'h00, 4'h0, 0, 1, 1, 1};
    vt[8]  = '{0, 8'h00, 4'h0, 0, 1, 1, 0};
    vt[9]  = '{0, 8'h00, 4'h0, 0, 1, 0, 0};
    vt[10] = '{1, 8'h20, 4'h5, 1, 0, 0, 1};
    vt[11] = '{1, 8'h21, 4'h6, 0, 0, 0, 2};
    vt[12] = '{1, 8'h22, 4'h7, 1, 0, 0, 3};
    vt[13] = '{1, 8'h23, 4'hA, 1, 1, 0, 0};
    vt[14] = '{1, 8'h24, 4'hB, 1, 0, 0, 0};
    vt[15] = '{1, 8'h25, 4'hC, 1, 0, 0, 0};
    vt[16] = '{1, 8'h26, 4'h8, 0, 0, 0, 1};
    vt[17] = '{0, 8'h00, 4'h0, 0, 1, 1, 0};
    vt[18] = '{0, 8'h00, 4'h0, 0, 0, 0, 0};
    vt[19] = '{0, 8'h00, 4'h0, 0, 0, 0, 0};
    vt[20] = '{1, 8'h27, 4'hD, 1, 0, 0, 1};
    vt[21] = '{0, 8'h00, 4'h0, 0, 1, 1, 0};

    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(vt[i].pv, vt[i].pc, vt[i].ix, vt[i].tk,
           vt[i].rv, vt[i].rt);
      chk($sformatf("vec%0d_count", i), 32'(bus.count),
          32'(vt[i].cnt));
    end

    for (int n = 0; n < 200; n++) begin
      logic rt;
      rt = ($urandom_range(3) == 0) ? 1'b0 : 1'b1;
      step(1'($urandom_range(1)), 8'($urandom),
           4'($urandom), 1'($urandom_range(3) != 0),
           1'($urandom_range(1)), rt);
    end

    for (int n = 0; n < 8; n++) begin
      if (mq.size() != 0) step(0, 0, 0, 0, 1, mq[0].taken);
    end
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(1, 8'h30, 4'h1, 1, 0, 0);
    step(1, 8'h31, 4'h2, 1, 0, 0);
    step(1, 8'h32, 4'h3, 1, 0, 0);
    step(1, 8'h33, 4'h4, 0, 1, 1);
    chk("pre_rst_count", 32'(bus.count), 3);
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    mq.delete();
    sbq.delete();
    mrec = 0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    step(1, 8'h40, 4'hE, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpredict_resolve_queue.md
# gpredict_resolve_queue

In-order branch resolution queue between the fetch-side global predictor and the execute stage. Captures each issued prediction (PC, BHT index, predicted direction), matches it against the in-order actual outcome from execute, and produces the registered BHT update and the misprediction redirect. On a mispredict it squashes all younger in-flight predictions and holds off new pushes for a fixed recovery window.

## Interface

Parameters:
- DEPTH, 4: queue entries; power of two, minimum 2.
- PC_W, 8: branch PC width.
- IDX_W, 4: BHT index width.
- RECOVER_CYCLES, 2: cycles pushes are blocked after a mispredict; minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- pred_valid  in  1  prediction issued this cycle.
- pred_pc  in  PC_W  PC of the predicted branch.
- pred_index  in  IDX_W  BHT index used for the prediction.
- pred_taken  in  1  predicted direction.
- pred_ready  out  1  queue accepts a push; combinational from registered state.
- res_valid  in  1  execute resolves the oldest branch.
- res_taken  in  1  actual outcome.
- res_ready  out  1  queue non-empty; combinational from registered state.
- upd_valid  out  1  BHT update strobe; one-cycle pulse.
- upd_index  out  IDX_W  BHT entry to update.
- upd_taken  out  1  actual outcome for the counter update.
- mispredict  out  1  one-cycle pulse; predicted and actual directions differ.
- redirect_pc  out  PC_W  PC of the mispredicted branch.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation

- Storage is a circular buffer of {pc, index, taken} with head and tail pointers. Pointers are $clog2(DEPTH)+1 bits wide, and the MSB disambiguates full from empty.
- Push: occurs when pred_valid && pred_ready. Writes the tail entry and increments the tail.
- Pop: occurs when res_valid && res_ready. Reads the head entry and increments the head.
- pred_ready = !full && state==NORMAL. res_ready = !empty.
- Each pop registers upd_valid=1, upd_index=entry.index and upd_taken=res_taken. Every resolved branch updates the BHT, whether or not it was mispredicted.
- When a pop has entry.taken != res_taken:
  - mispredict=1 and redirect_pc=entry.pc.
  - The tail is set to head+1, which empties the queue after this pop.
  - A push in the same cycle is discarded.
  - The FSM moves to RECOVER.
- FSM states:
  - NORMAL to RECOVER on a mispredict pop; the recovery counter is loaded with RECOVER_CYCLES-1.
  - RECOVER decrements the counter each cycle and returns to NORMAL when the counter reaches 0.
  - In RECOVER, pred_ready=0. Pops cannot occur because the queue is empty.
- Push with no accepted pop: count increments.
- Push and pop in the same cycle: count is unchanged. A push into a full queue is not accepted even if a pop occurs that cycle; there is no bypass.
- res_valid while empty: ignored, no update is produced.
- Pointer arithmetic is modulo 2·DEPTH, and wrap-around is natural.

## Timing

- Reset values while reset_n is low: all pointers 0, count=0, state=NORMAL, upd_valid=0, upd_index=0, upd_taken=0, mispredict=0, redirect_pc=0. As a result pred_ready=1 and res_ready=0.
- Reset takes effect immediately on assertion (asynchronous); a mid-operation reset drops all entries. Deassertion is synchronized by the system.
- Update and mispredict latency is 1 cycle: outputs are valid in the cycle after the pop handshake, for exactly one cycle.
- After a mispredict pop at cycle T: pred_ready=0 for cycles T+1 through T+RECOVER_CYCLES, and returns to 1 at T+RECOVER_CYCLES+1.
- Back-to-back pops produce back-to-back upd_valid pulses.

## Structure

- Shared package holds:
  - the entry record typedef {pc, index, taken};
  - the state enum NORMAL/RECOVER;
  - default width constants PC_W=8 and IDX_W=4, matching the predictor.
- One sub-module, gpredict_rq_storage: a circular-buffer register array with write-at-tail and read-at-head. Pointers, FSM and outputs stay in the top level.

## Test plan

- Reset, then 4 pushes (pc 0x10–0x13, taken=1), then 4 correct pops -> upd_valid ×4 with upd_index in push order, mispredict never asserted, count returns 0.
- Fill to DEPTH=4 -> pred_ready=0. Push and pop in the same cycle -> push rejected, count 4→3.
- Push 3 entries; the first has pc=0x20 and taken=1; resolve it with res_taken=0 -> next cycle mispredict=1, redirect_pc=0x20, upd_taken=0, count=0. pred_ready=0 for 2 cycles, then 1.
- Mispredict pop with a simultaneous pred_valid -> pushed entry discarded, count=0.
- res_valid with the queue empty -> no upd_valid, pointers unchanged.
- Assert reset_n=0 mid-stream with 3 entries held -> outputs immediately at reset values, count=0, pred_ready=1.
